// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversampling
// ratio, read-data field layout and the baud tick divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned RDATA_DATA_LSB = 0;
  localparam int unsigned RDATA_DATA_MSB = 7;
  localparam int unsigned RDATA_FERR_BIT = 8;
  localparam int unsigned ENTRY_W        = RDATA_FERR_BIT + 1;

  // Clocks per oversample tick; truncating division, never below 1.
  function automatic int unsigned tick_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: extra pointer MSB distinguishes full from empty; a push
// into a full FIFO is accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    o_empty = (wptr_q == rptr_q);
    o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    o_rdata = mem_q[rptr_q[AW-1:0]];
    do_pop  = i_pop & ~o_empty;
    do_push = i_push & (~o_full | do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, framing/break detection,
// receive FIFO and a one-acknowledge-per-request bus read handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_rx_valid,
  output logic        o_overrun,
  input  logic        UART_RX
);

  localparam int unsigned DIV = tick_divisor(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic              sync1_q, sync2_q, rx_s;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick;

  rx_state_e         state_q, state_d;
  logic [3:0]        sample_cnt_q, sample_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              push_q, push_d;
  logic [ENTRY_W-1:0] push_data_q, push_data_d;

  logic              armed_q, armed_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              overrun_q, overrun_d;

  logic [ENTRY_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic              pop;

  assign rx_s = sync2_q;

  always_comb begin
    tick       = (tick_cnt_q == TW'(DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d      = ST_START;
          sample_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sample_cnt_q == 4'd7) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d      = ST_DATA;
              sample_cnt_d = '0;
              bit_cnt_d    = '0;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            push_d      = 1'b1;
            push_data_d = {~rx_s, shift_q};
            state_d     = rx_s ? ST_IDLE : ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Armed re-arms only while request is low, so a held request is acked once.
  always_comb begin
    pop     = i_request & ~fifo_empty & armed_q;
    armed_d = armed_q;
    if (!i_request)  armed_d = 1'b1;
    else if (pop)    armed_d = 1'b0;
    ready_d = pop;
    rdata_d = rdata_q;
    if (pop) begin
      rdata_d = '0;
      rdata_d[RDATA_FERR_BIT:RDATA_DATA_LSB] = fifo_rdata;
    end
    overrun_d = overrun_q;
    if (push_q && fifo_full && !pop) overrun_d = 1'b1;
    else if (pop)                    overrun_d = 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      tick_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      armed_q      <= 1'b0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= UART_RX;
      sync2_q      <= sync1_q;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      armed_q      <= armed_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (push_q),
    .i_wdata (push_data_q),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_ready    = ready_q;
  assign o_rdata    = rdata_q;
  assign o_rx_valid = ~fifo_empty;
  assign o_overrun  = overrun_q;

  logic unused_ok;
  assign unused_ok = ^{RDATA_DATA_MSB[0]};

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven at 16 clocks per bit and the
// read-back data is checked against a queue-based model of the FIFO.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        request = 1'b0;
  logic        ready;
  logic [31:0] rdata;
  logic        rx_valid;
  logic        overrun;
  logic        line = 1'b1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          ready_cnt = 0;
  logic [31:0] last_rdata = '0;

  logic [8:0]  model_q[$];
  logic        model_ovr = 1'b0;

  uart_rx #(
    .CLOCK_RATE (1600000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (16)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_request  (request),
    .o_ready    (ready),
    .o_rdata    (rdata),
    .o_rx_valid (rx_valid),
    .o_overrun  (overrun),
    .UART_RX    (line)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready) begin
      ready_cnt++;
      last_rdata = rdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic hold_line(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  // Full frame preceded by an idle-high gap; the model records the byte once
  // the stop bit has been driven, when the DUT has already pushed it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
    hold_line(1'b1, gap);
    hold_line(1'b0, 16);
    for (int i = 0; i < 8; i++) hold_line(b[i], 16);
    hold_line(stop, 16);
    if (model_q.size() < 16) model_q.push_back({~stop, b});
    else                     model_ovr = 1'b1;
  endtask

  task automatic do_read(input string tag);
    logic [31:0] exp;
    logic        seen;
    seen = 1'b0;
    exp  = '0;
    if (model_q.size() != 0) exp[8:0] = model_q.pop_front();
    request = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_ack"}, {31'b0, seen}, 32'd1);
    if (seen) check_eq({tag, "_data"}, rdata, exp);
    request = 1'b0;
    model_ovr = 1'b0;
    @(negedge clk);
    check_eq({tag, "_single"}, {31'b0, ready}, 32'd0);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_valid"}, {31'b0, rx_valid}, {31'b0, model_q.size() != 0});
    check_eq({tag, "_ovr"},   {31'b0, overrun},  {31'b0, model_ovr});
  endtask

  initial begin
    int c0;
    repeat (4) @(negedge clk);
    check_eq("rst_ready", {31'b0, ready}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_valid", {31'b0, rx_valid}, 32'd0);
    check_eq("rst_ovr",   {31'b0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h55, 1'b1, 16);
    check_status("f55");
    do_read("rd55");
    @(negedge clk);
    check_status("f55_after");

    hold_line(1'b0, 4);
    hold_line(1'b1, 200);
    check_eq("glitch_valid", {31'b0, rx_valid}, 32'd0);

    send_frame(8'hA3, 1'b0, 16);
    hold_line(1'b0, 40);
    send_frame(8'h12, 1'b1, 16);
    check_status("brk");
    do_read("rdA3");
    do_read("rd12");

    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 16);
    check_status("full");
    do_read("ovr_rd0");
    check_eq("ovr_clear", {31'b0, overrun}, 32'd0);
    for (int i = 1; i < 16; i++) do_read("ovr_rd");
    @(negedge clk);
    check_status("drained");

    c0 = ready_cnt;
    request = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h7E, 1'b1, 16);
    void'(model_q.pop_front());
    repeat (40) @(negedge clk);
    check_eq("held_pulses", ready_cnt - c0, 32'd1);
    check_eq("held_data", last_rdata, 32'h0000007E);
    request = 1'b0;
    repeat (2) @(negedge clk);
    check_status("held_after");

    send_frame(8'h31, 1'b1, 16);
    send_frame(8'h42, 1'b1, 16);
    hold_line(1'b1, 16);
    hold_line(1'b0, 16);
    hold_line(1'b0, 16);
    hold_line(1'b0, 16);
    hold_line(1'b1, 16);
    hold_line(1'b0, 8);
    #3;
    rst_n = 1'b0;
    line  = 1'b1;
    #1;
    check_eq("arst_ready", {31'b0, ready}, 32'd0);
    check_eq("arst_rdata", rdata, 32'd0);
    check_eq("arst_valid", {31'b0, rx_valid}, 32'd0);
    check_eq("arst_ovr",   {31'b0, overrun}, 32'd0);
    model_q.delete();
    model_ovr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'hC4, 1'b1, 16);
    do_read("rdC4");

    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       stop;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, 16 + int'($urandom_range(0, 20)));
      check_status("rnd");
      if ($urandom_range(0, 2) == 0 && model_q.size() != 0) do_read("rnd_rd");
    end
    hold_line(1'b1, 20);
    while (model_q.size() != 0) do_read("rnd_drain");
    @(negedge clk);
    check_status("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
